// File: rtl/alu_pkg.sv
// Shared constants and op record for the ALU control issue stage.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1110;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0] ctrl;
    logic [4:0] shamt;
    logic       illegal;
  } alu_op_t;

  localparam alu_op_t ALU_OP_ILLEGAL = '{ctrl: ALU_AND, shamt: 5'd0, illegal: 1'b1};

  function automatic alu_op_t mk_op(input logic [3:0] ctrl, input logic [4:0] shamt);
    mk_op = '{ctrl: ctrl, shamt: shamt, illegal: 1'b0};
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I field decoder producing the ALU control code and shift amount.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [4:0]  rs2_lo,
  output alu_op_t     op
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] imm_sh;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_sh = instr[24:20];
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  always_comb begin
    op = ALU_OP_ILLEGAL;
    unique case (opcode)
      OPC_R: begin
        // every R-type op except SUB needs the base funct7
        if (f7 == F7_BASE) begin
          unique case (f3)
            3'b000:  op = mk_op(ALU_ADD,  rs2_lo);
            3'b001:  op = mk_op(ALU_SLL,  rs2_lo);
            3'b011:  op = mk_op(ALU_SLTU, rs2_lo);
            3'b100:  op = mk_op(ALU_XOR,  rs2_lo);
            3'b101:  op = mk_op(ALU_SRL,  rs2_lo);
            3'b110:  op = mk_op(ALU_OR,   rs2_lo);
            3'b111:  op = mk_op(ALU_AND,  rs2_lo);
            default: op = ALU_OP_ILLEGAL;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          op = mk_op(ALU_SUB, rs2_lo);
        end
      end
      OPC_I: begin
        unique case (f3)
          3'b000:  op = mk_op(ALU_ADD,  imm_sh);
          3'b001:  op = (f7 == F7_BASE) ? mk_op(ALU_SLL, imm_sh) : ALU_OP_ILLEGAL;
          3'b011:  op = mk_op(ALU_SLTU, imm_sh);
          3'b100:  op = mk_op(ALU_XOR,  imm_sh);
          3'b101:  op = (f7 == F7_BASE) ? mk_op(ALU_SRL, imm_sh) : ALU_OP_ILLEGAL;
          3'b110:  op = mk_op(ALU_OR,   imm_sh);
          3'b111:  op = mk_op(ALU_AND,  imm_sh);
          default: op = ALU_OP_ILLEGAL;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
        op = mk_op(ALU_ADD, 5'd0);
      end
      OPC_BRANCH: begin
        unique case (f3)
          3'b000, 3'b001: op = mk_op(ALU_SUB,  5'd0);
          3'b110, 3'b111: op = mk_op(ALU_SLTU, 5'd0);
          default:        op = ALU_OP_ILLEGAL;
        endcase
      end
      default: op = ALU_OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Registered valid/ready issue stage with a 2-entry skid buffer for decoded ALU ops.
// Optional saturating performance counters are built when ALU_CTRL_PERF_EN is defined.
module alu_ctrl_issue
  import alu_pkg::*;
#(
  parameter int CTR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [4:0]       in_rs2_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_ctrl,
  output logic [4:0]       out_shamt,
  output logic             out_illegal,
  output logic [CTR_W-1:0] perf_issued,
  output logic [CTR_W-1:0] perf_illegal
);

  alu_op_t dec_op;
  alu_op_t m_op;
  alu_op_t s_op;
  logic    m_valid;
  logic    s_valid;
  logic    accept;
  logic    pop;

  alu_ctrl_dec u_dec (
    .instr  (in_instr),
    .rs2_lo (in_rs2_lo),
    .op     (dec_op)
  );

  // s_valid is a flop, so in_ready is registered with no input-to-output path
  assign in_ready = ~s_valid;
  assign accept   = in_valid & in_ready;
  assign pop      = m_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_op    <= '0;
      s_op    <= '0;
    end else if (!m_valid || pop) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_op    <= s_op;
        s_valid <= accept;
        if (accept) s_op <= dec_op;
      end else begin
        m_valid <= accept;
        if (accept) m_op <= dec_op;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_op    <= dec_op;
    end
  end

  assign out_valid    = m_valid;
  assign out_alu_ctrl = m_op.ctrl;
  assign out_shamt    = m_op.shamt;
  assign out_illegal  = m_op.illegal;

`ifdef ALU_CTRL_PERF_EN
  logic [CTR_W-1:0] issued_q;
  logic [CTR_W-1:0] illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_q  <= '0;
      illegal_q <= '0;
    end else if (pop) begin
      if (issued_q != '1) issued_q <= issued_q + CTR_W'(1);
      if (m_op.illegal && illegal_q != '1) illegal_q <= illegal_q + CTR_W'(1);
    end
  end

  assign perf_issued  = issued_q;
  assign perf_illegal = illegal_q;
`else
  assign perf_issued  = '0;
  assign perf_illegal = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Scoreboard bench for alu_ctrl_issue: driver pushes expected ops, monitor pops on each issue.
module tb_alu_ctrl_issue;

  localparam int CTR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [4:0]       in_rs2_lo;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_alu_ctrl;
  logic [4:0]       out_shamt;
  logic             out_illegal;
  logic [CTR_W-1:0] perf_issued;
  logic [CTR_W-1:0] perf_illegal;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  alu_ctrl_issue #(.CTR_W(CTR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_rs2_lo    (in_rs2_lo),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_shamt    (out_shamt),
    .out_illegal  (out_illegal),
    .perf_issued  (perf_issued),
    .perf_illegal (perf_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {ctrl[3:0], shamt[4:0], illegal}
  task automatic send(input logic [31:0] instr, input logic [4:0] rs2, input logic [9:0] e);
    int n = 0;
    in_valid  = 1'b1;
    in_instr  = instr;
    in_rs2_lo = rs2;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready=%b instr=%h", in_ready, instr);
    end else begin
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // monitor: sample just before the active edge, when inputs and outputs are settled
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_op: got %h with empty queue",
                   {out_alu_ctrl, out_shamt, out_illegal});
        end else begin
          e = exp_q.pop_front();
          chk("op_out", {22'd0, out_alu_ctrl, out_shamt, out_illegal}, {22'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  logic [31:0] sw_instr[14] = '{
    32'h40000033, 32'h00709093, 32'h00001033, 32'h00006063, 32'h00002003,
    32'h40005033, 32'h00304013, 32'h00002033, 32'h00000063, 32'h12345037,
    32'h0000007F, 32'h20005033, 32'h00005033, 32'h00A06013
  };
  logic [4:0] sw_rs2[14] = '{
    5'd0, 5'd0, 5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0
  };
  logic [9:0] sw_exp[14] = '{
    {4'b0110, 5'd0,  1'b0},  // SUB
    {4'b0011, 5'd7,  1'b0},  // SLLI 7
    {4'b0011, 5'd19, 1'b0},  // SLL rs2=19
    {4'b1110, 5'd0,  1'b0},  // BLTU
    {4'b0010, 5'd0,  1'b0},  // LW
    {4'b0000, 5'd0,  1'b1},  // SRA
    {4'b1001, 5'd3,  1'b0},  // XORI imm 3
    {4'b0000, 5'd0,  1'b1},  // SLT
    {4'b0110, 5'd0,  1'b0},  // BEQ
    {4'b0010, 5'd0,  1'b0},  // LUI
    {4'b0000, 5'd0,  1'b1},  // unknown opcode
    {4'b0000, 5'd0,  1'b1},  // SRL bad funct7
    {4'b0100, 5'd5,  1'b0},  // SRL rs2=5
    {4'b0001, 5'd10, 1'b0}   // ORI imm 10
  };

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00000033;
    in_rs2_lo = 5'd0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ctrl", out_alu_ctrl, 0);
    chk("rst_shamt", out_shamt, 0);
    chk("rst_illegal", out_illegal, 0);
    chk("rst_perf_issued", perf_issued, 0);

    rst_n = 1'b1;
    exp_q.push_back({4'b0010, 5'd0, 1'b0});
    @(negedge clk);
    chk("first_op_latency", out_valid, 1);
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 14; i++) send(sw_instr[i], sw_rs2[i], sw_exp[i]);
    drain();

    // back-pressure: op1 reaches M, then stall while ops 2-4 arrive
    send(32'h00500013, 5'd0, {4'b0010, 5'd5, 1'b0});
    out_ready = 1'b0;
    fork
      begin
        send(32'h00004033, 5'd9, {4'b1001, 5'd9, 1'b0});
        send(32'h00001063, 5'd0, {4'b0110, 5'd0, 1'b0});
        send(32'h00000017, 5'd0, {4'b0010, 5'd0, 1'b0});
      end
      begin
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_hold_op", {out_alu_ctrl, out_shamt, out_illegal}, {4'b0010, 5'd5, 1'b0});
          @(negedge clk);
        end
        chk("bp_pop_s_full_ready", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("skid_to_main", {out_alu_ctrl, out_shamt, out_illegal}, {4'b1001, 5'd9, 1'b0});
        chk("bp_in_ready_back", in_ready, 1);
      end
    join
    drain();

    // reset while both entries are full: held ops must vanish
    out_ready = 1'b0;
    send(32'h00007033, 5'd2, {4'b0000, 5'd2, 1'b0});
    send(32'h00103013, 5'd0, {4'b1110, 5'd1, 1'b0});
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    rst_n = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    send(32'h00A06013, 5'd0, {4'b0001, 5'd10, 1'b0});
    drain();
    chk("post_rst_idle", out_valid, 0);

    // 20 ops, 3 illegal; issue counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      if (i % 7 == 3) send(32'h40005033, 5'd0, {4'b0000, 5'd0, 1'b1});
      else            send(32'h00000033, 5'd1, {4'b0010, 5'd1, 1'b0});
    end
    drain();
`ifdef ALU_CTRL_PERF_EN
    chk("perf_issued", perf_issued, 15);
    chk("perf_illegal", perf_illegal, 3);
`else
    chk("perf_issued_off", perf_issued, 0);
    chk("perf_illegal_off", perf_illegal, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
